// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: FSM state encoding and register-zero constant.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hazState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch flush, data-memory wait with timeout abort.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ifIdRs,
  input  logic [4:0]  ifIdRt,
  input  logic        ifIdUsesRt,
  input  logic [4:0]  idExRt,
  input  logic        idExMemToReg,
  input  logic        branchTaken,
  input  logic        memReq,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        pipeWrite,
  output logic        memError,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount,
  output hazState_t   stateDbg
);

  // Handshake: memReq qualifies the MEM stage access; memReady completes it in the same
  // cycle. A request with memReady low freezes every pipeline register until ready or timeout.

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  hazState_t  state;
  hazState_t  nextState;
  logic [7:0] waitCnt;
  logic       loadUse;
  logic       waitStart;
  logic       waitTimeout;

  assign loadUse = idExMemToReg && (idExRt != REG_ZERO) &&
                   ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));

  assign stateDbg = state;

  always_comb begin
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    pipeWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExFlush   = 1'b0;
    waitStart   = 1'b0;
    waitTimeout = 1'b0;
    nextState   = RUN;
    if (!reset) begin
      case (state)
        RUN, LOAD_STALL: begin
          if (memReq && !memReady) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            pipeWrite = 1'b0;
            waitStart = 1'b1;
            nextState = MEM_WAIT;
          end else if (branchTaken) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
          end else if ((state == RUN) && loadUse) begin
            // Hold PC and IF/ID for one cycle while a bubble enters ID/EX.
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
            nextState = LOAD_STALL;
          end
        end
        MEM_WAIT: begin
          if (!memReady) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            pipeWrite = 1'b0;
            if (waitCnt == TIMEOUT_LIMIT) begin
              waitTimeout = 1'b1;
            end else begin
              nextState = MEM_WAIT;
            end
          end
        end
        default: nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      waitCnt  <= 8'd0;
      memError <= 1'b0;
    end else begin
      state <= nextState;
      if (waitStart) begin
        waitCnt <= 8'd1;
      end else if ((state == MEM_WAIT) && !memReady && (waitCnt != 8'hFF)) begin
        waitCnt <= waitCnt + 8'd1;
      end
      if (waitTimeout) begin
        memError <= 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCount <= 32'd0;
      flushCount <= 32'd0;
    end else begin
      if (!pcWrite) begin
        stallCount <= stallCount + 32'd1;
      end
      if (ifIdFlush) begin
        flushCount <= flushCount + 32'd1;
      end
    end
  end
`else
  assign stallCount = 32'd0;
  assign flushCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit; a second instance uses TIMEOUT_CYCLES=3.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  localparam int W = 73;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ifIdRs = '0;
  logic [4:0]  ifIdRt = '0;
  logic        ifIdUsesRt = 1'b0;
  logic [4:0]  idExRt = '0;
  logic        idExMemToReg = 1'b0;
  logic        branchTaken = 1'b0;
  logic        memReq = 1'b0;
  logic        memReady = 1'b0;

  logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeWrite, memError;
  logic [31:0] stallCount, flushCount;
  hazState_t   stateDbg;
  logic        pcWriteB, ifIdWriteB, ifIdFlushB, idExFlushB, pipeWriteB, memErrorB;
  logic [31:0] stallCountB, flushCountB;
  hazState_t   stateDbgB;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           compared = 0;
  int           mismatched = 0;
  int           stallExp = 0;
  int           flushExp = 0;

  localparam logic [5:0] DEF   = 6'b110010;
  localparam logic [5:0] DEFE  = 6'b110011;
  localparam logic [5:0] STALL = 6'b000110;
  localparam logic [5:0] BRAN  = 6'b111110;
  localparam logic [5:0] WAIT  = 6'b000000;

  hazard_unit dut (
    .clock(clock), .reset(reset), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRt(ifIdUsesRt),
    .idExRt(idExRt), .idExMemToReg(idExMemToReg), .branchTaken(branchTaken),
    .memReq(memReq), .memReady(memReady), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
    .ifIdFlush(ifIdFlush), .idExFlush(idExFlush), .pipeWrite(pipeWrite), .memError(memError),
    .stallCount(stallCount), .flushCount(flushCount), .stateDbg(stateDbg)
  );

  hazard_unit #(.TIMEOUT_CYCLES(3)) dutTo (
    .clock(clock), .reset(reset), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRt(ifIdUsesRt),
    .idExRt(idExRt), .idExMemToReg(idExMemToReg), .branchTaken(branchTaken),
    .memReq(memReq), .memReady(memReady), .pcWrite(pcWriteB), .ifIdWrite(ifIdWriteB),
    .ifIdFlush(ifIdFlushB), .idExFlush(idExFlushB), .pipeWrite(pipeWriteB), .memError(memErrorB),
    .stallCount(stallCountB), .flushCount(flushCountB), .stateDbg(stateDbgB)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Driver: applies one cycle of inputs just after the rising edge.
  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic [4:0] exRt, input logic mtr,
                       input logic br, input logic req, input logic rdy);
    @(posedge clock);
    #1;
    reset = rst; ifIdRs = rs; ifIdRt = rt; ifIdUsesRt = ur; idExRt = exRt;
    idExMemToReg = mtr; branchTaken = br; memReq = req; memReady = rdy;
  endtask

  // Pushes the expected view of this cycle; counter model follows the main instance.
  task automatic expect_out(input string nm, input bit useB, input logic [5:0] ctl,
                            input hazState_t st);
    logic [31:0] sc, fc;
    sc = 32'd0;
    fc = 32'd0;
`ifdef HAZARD_STATS_EN
    if (!useB) begin
      sc = 32'(stallExp);
      fc = 32'(flushExp);
    end
`endif
    exp_q.push_back({useB, ctl, st, sc, fc});
    name_q.push_back(nm);
    if (!useB) begin
      if (reset) begin
        stallExp = 0;
        flushExp = 0;
      end else begin
        if (!ctl[5]) stallExp++;
        if (ctl[3]) flushExp++;
      end
    end
  endtask

  // Monitor / scoreboard
  logic [W-1:0] monExp, monAct;
  string        monName;
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      monExp  = exp_q.pop_front();
      monName = name_q.pop_front();
      if (monExp[W-1])
        monAct = {1'b1, pcWriteB, ifIdWriteB, ifIdFlushB, idExFlushB, pipeWriteB, memErrorB,
                  stateDbgB, 64'd0};
      else
        monAct = {1'b0, pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeWrite, memError,
                  stateDbg, stallCount, flushCount};
      compared++;
      if (monAct !== monExp) begin
        mismatched++;
        $display("FAIL %s: got %h required %h", monName, monAct, monExp);
      end
    end
  end

  initial begin
    // Reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("reset_a", 0, DEF, RUN);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("reset_b", 0, DEF, RUN);

    // Load-use on rs, single bubble even with inputs held
    drive(0, 8, 0, 0, 8, 1, 0, 0, 0); expect_out("loaduse_stall", 0, STALL, RUN);
    drive(0, 8, 0, 0, 8, 1, 0, 0, 0); expect_out("loaduse_release", 0, DEF, LOAD_STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("idle", 0, DEF, RUN);
    drive(0, 3, 8, 1, 8, 1, 0, 0, 0); expect_out("loaduse_rt", 0, STALL, RUN);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("loaduse_rt_release", 0, DEF, LOAD_STALL);

    // No-hazard boundaries
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); expect_out("reg_zero", 0, DEF, RUN);
    drive(0, 1, 9, 0, 9, 1, 0, 0, 0); expect_out("rt_unused", 0, DEF, RUN);
    drive(0, 8, 0, 0, 8, 0, 0, 0, 0); expect_out("no_load", 0, DEF, RUN);

    // Branch beats load-use
    drive(0, 8, 0, 0, 8, 1, 1, 0, 0); expect_out("branch_over_load", 0, BRAN, RUN);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("after_branch", 0, DEF, RUN);
    drive(0, 8, 0, 0, 8, 1, 0, 0, 0); expect_out("stall_before_br", 0, STALL, RUN);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); expect_out("branch_in_stall", 0, BRAN, LOAD_STALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("after_stall_br", 0, DEF, RUN);

    // Memory wait of four cycles, then ready with branch ignored
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("reset_mem", 0, DEF, RUN);
    drive(0, 8, 0, 0, 8, 1, 1, 1, 0); expect_out("mem_wait_prio", 0, WAIT, RUN);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_out("mem_wait", 0, WAIT, MEM_WAIT);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1); expect_out("mem_ready", 0, DEF, MEM_WAIT);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("after_ready", 0, DEF, RUN);

    // Timeout on the TIMEOUT_CYCLES=3 instance
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("reset_to", 0, DEF, RUN);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    expect_out("to_start", 0, WAIT, RUN); expect_out("to_start_b", 1, WAIT, RUN);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      expect_out("to_wait", 0, WAIT, MEM_WAIT); expect_out("to_wait_b", 1, WAIT, MEM_WAIT);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("long_wait", 0, WAIT, MEM_WAIT); expect_out("to_abort_b", 1, DEFE, RUN);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_out("long_ready", 0, DEF, MEM_WAIT); expect_out("memerr_hold_b", 1, DEFE, RUN);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("long_done", 0, DEF, RUN); expect_out("memerr_sticky_b", 1, DEFE, RUN);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset_err", 0, DEF, RUN); expect_out("memerr_in_reset_b", 1, DEFE, RUN);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("post_reset", 0, DEF, RUN); expect_out("memerr_cleared_b", 1, DEF, RUN);

    // Reset during the second memory-wait cycle
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_out("rw_start", 0, WAIT, RUN);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); expect_out("rw_reset", 0, DEF, MEM_WAIT);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("rw_after", 0, DEF, RUN);

    @(negedge clock);
    @(negedge clock);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
